// File: rtl/led_pkg.sv
// Shared types and default constants for the LED pattern arbiter/scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } led_state_e;

  localparam int LED_W_DEF    = 8;
  localparam int IDLE_PAT_DEF = 0;

endpackage

// File: rtl/led_rr_pick.sv
// Round-robin winner search: first valid requester after ptr_i, wrapping modulo NREQ.
module led_rr_pick
  import led_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  win_o,
  output logic            found_o
);

  logic [IDW-1:0] sel;

  always_comb begin
    found_o = 1'b0;
    win_o   = '0;
    sel     = '0;
    // k=NREQ wraps back to ptr_i itself, so the last winner gets lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      sel = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found_o && valid_i[sel]) begin
        found_o = 1'b1;
        win_o   = sel;
      end
    end
  end

endmodule

// File: rtl/led_arb_sched.sv
// Round-robin LED pattern scheduler: grants one requester at a time and holds its
// pattern for a tick-based duration. Define LED_ARB_PREEMPT_EN to let requester 0 preempt a hold.
module led_arb_sched
  import led_pkg::*;
#(
  parameter int               LED_W     = LED_W_DEF,
  parameter int               NREQ      = 3,
  parameter int               DUR_W     = 8,
  parameter int               PRESC_DIV = 5000000,
  parameter logic [LED_W-1:0] IDLE_PAT  = LED_W'(IDLE_PAT_DEF)
) (
  input  logic                     OSC_50m,
  input  logic                     FPGA_RSTn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*LED_W-1:0]    req_pattern,
  input  logic [NREQ*DUR_W-1:0]    req_dur,
  output logic [LED_W-1:0]         USER_LED,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(PRESC_DIV);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  led_state_e       state_q, state_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [DUR_W-1:0] hold_q, hold_d;
  logic [IDW-1:0]   pick_win;
  logic             pick_found;
  logic [LED_W-1:0] sel_pat;
  logic [DUR_W-1:0] sel_dur;

  // Asserts asynchronously, releases two clock edges after FPGA_RSTn rises
  always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
    if (!FPGA_RSTn) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign tick    = (presc_q == PW'(PRESC_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  led_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .win_o   (pick_win),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    led_d   = led_q;
    hold_d  = hold_q;
    sel_pat = req_pattern[win_q*LED_W +: LED_W];
    sel_dur = req_dur[win_q*DUR_W +: DUR_W];
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d   = pick_win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Transfer edge never decrements: the hold counts from the next tick on
        if (req_valid[win_q]) begin
          led_d   = sel_pat;
          hold_d  = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
          gid_d   = win_q;
          ptr_d   = win_q;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
`ifdef LED_ARB_PREEMPT_EN
        if (gid_q != '0 && req_valid[0]) begin
          win_d   = '0;
          state_d = LOAD;
        end else
`endif
        if (tick) begin
          hold_d = hold_q - DUR_W'(1);
          if (hold_q == DUR_W'(1)) begin
            led_d   = IDLE_PAT;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OSC_50m or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      gid_q   <= '0;
      led_q   <= IDLE_PAT;
      hold_q  <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LOAD) req_ready = NREQ'(1) << win_q;
  end

  assign busy     = (state_q != IDLE);
  assign USER_LED = led_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_led_arb_sched.sv
// Self-checking bench for led_arb_sched: directed scenarios plus randomized held-request
// rounds, checked against a transaction-level round-robin/hold-time model.
module tb_led_arb_sched;

  localparam int NREQ = 3;
  localparam int LW   = 8;
  localparam int DW   = 8;
  localparam int PD   = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NREQ-1:0]  valid = '0;
  logic [NREQ-1:0]  ready;
  logic [NREQ*LW-1:0] pat = '0;
  logic [NREQ*DW-1:0] dur = '0;
  logic [LW-1:0]    led;
  logic             busy;
  logic [1:0]       gid;

  int n_cmp = 0;
  int n_err = 0;
  int since_xfer = 0;
  int mptr = NREQ - 1;

  always #5 clk = ~clk;

  led_arb_sched #(.LED_W(LW), .NREQ(NREQ), .DUR_W(DW), .PRESC_DIV(PD), .IDLE_PAT(8'h00)) dut (
    .OSC_50m     (clk),
    .FPGA_RSTn   (rstn),
    .req_valid   (valid),
    .req_ready   (ready),
    .req_pattern (pat),
    .req_dur     (dur),
    .USER_LED    (led),
    .busy        (busy),
    .grant_id    (gid)
  );

  task automatic step();
    @(posedge clk);
    #1;
    since_xfer++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      $error("check %s", tag);
    end
  endtask

  // Reference: first valid index after the last winner, wrapping
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [LW-1:0] p, input logic [DW-1:0] d);
    pat[i*LW +: LW] = p;
    dur[i*DW +: DW] = d;
    valid[i] = 1'b1;
  endtask

  task automatic grant_start(input int who, input logic [LW-1:0] p, input int budget, input bit drop);
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[who] = 1'b1;
    for (int c = 0; c < budget; c++) begin
      step();
      if (ready != '0) break;
    end
    chk("ready_onehot", ready, exp_rdy);
    chk("busy_in_load", busy, 1);
    step();
    since_xfer = 0;
    chk("ready_one_cycle", ready, 0);
    chk("led_after_xfer", led, p);
    chk("grant_id", gid, who);
    if (drop) valid = '0;
    mptr = who;
  endtask

  task automatic grant_finish(input logic [LW-1:0] p, input int d, input int budget);
    bit glitch;
    glitch = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (!busy) break;
      if (led !== p) glitch = 1'b1;
    end
    chk("led_steady_in_hold", glitch, 0);
    chk("led_idle_after_hold", led, 8'h00);
    chk("busy_after_hold", busy, 0);
    chk_rng("hold_cycles", since_xfer, (d - 1) * PD + 1, d * PD);
  endtask

  // Keeps the current valid mask asserted for n grants; drops everything after the last one
  task automatic run_held(input int n);
    int w, d;
    logic [LW-1:0] p;
    for (int g = 0; g < n; g++) begin
      w = pick(valid, mptr);
      p = pat[w*LW +: LW];
      d = int'(dur[w*DW +: DW]);
      if (d == 0) d = 1;
      grant_start(w, p, 6, g == n - 1);
      grant_finish(p, d, d * PD + 8);
    end
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_led", led, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_gid", gid, 0);
    rstn = 1'b1;
    repeat (3) step();

    // Single request, 3 ticks
    set_req(0, 8'hA5, 8'd3);
    grant_start(0, 8'hA5, 4, 1);
    grant_finish(8'hA5, 3, 20);
    repeat (3) step();
    chk("idle_led_stays", led, 8'h00);
    chk("idle_busy_stays", busy, 0);

    // Zero duration behaves as one tick
    set_req(1, 8'hFF, 8'd0);
    grant_start(1, 8'hFF, 4, 1);
    grant_finish(8'hFF, 1, 8);

    // Valid withdrawn while in LOAD
    set_req(2, 8'h66, 8'd2);
    step();
    chk("load_ready2", ready, 3'b100);
    valid = '0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_led", led, 8'h00);
    chk("abort_gid", gid, 1);

    // rr pointer must still be 1, so requester 2 beats requester 0
    set_req(0, 8'h11, 8'd1);
    set_req(2, 8'h22, 8'd2);
    chk("model_pick_after_abort", pick(valid, mptr), 2);
    run_held(2);

    // Reset in the middle of a hold
    set_req(1, 8'h3C, 8'd5);
    grant_start(1, 8'h3C, 4, 1);
    repeat (4) step();
    rstn = 1'b0;
    #1;
    chk("midhold_rst_led", led, 8'h00);
    chk("midhold_rst_busy", busy, 0);
    chk("midhold_rst_ready", ready, 0);
    chk("midhold_rst_gid", gid, 0);
    repeat (2) step();
    rstn = 1'b1;
    repeat (3) step();
    mptr = NREQ - 1;

    // Fairness with all three held: 0,1,2,0
    set_req(0, 8'h01, 8'd1);
    set_req(1, 8'h02, 8'd1);
    set_req(2, 8'h04, 8'd1);
    grant_start(0, 8'h01, 4, 0); grant_finish(8'h01, 1, 8);
    grant_start(1, 8'h02, 4, 0); grant_finish(8'h02, 1, 8);
    grant_start(2, 8'h04, 4, 0); grant_finish(8'h04, 1, 8);
    grant_start(0, 8'h01, 4, 1); grant_finish(8'h01, 1, 8);

    // Randomized held masks
    for (int r = 0; r < 8; r++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, 7));
      for (int i = 0; i < NREQ; i++)
        if (m[i]) set_req(i, LW'($urandom_range(1, 255)), DW'($urandom_range(0, 3)));
      run_held($urandom_range(1, 4));
    end

    // Requester 0 arriving during a long hold of requester 2
    set_req(2, 8'h5A, 8'd10);
    grant_start(2, 8'h5A, 4, 1);
    repeat (5) step();
    set_req(0, 8'h81, 8'd1);
`ifdef LED_ARB_PREEMPT_EN
    grant_start(0, 8'h81, 2, 1);
    grant_finish(8'h81, 1, 8);
`else
    repeat (3) step();
    chk("no_preempt_led", led, 8'h5A);
    chk("no_preempt_busy", busy, 1);
    grant_finish(8'h5A, 10, 50);
    grant_start(0, 8'h81, 4, 1);
    grant_finish(8'h81, 1, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_arb_sched.md
LED_ARB_SCHED -- requirements
Module: led_arb_sched

Interface
- REQ-001 Parameter LED_W, default 8, SHALL set the LED array width.
- REQ-002 Parameter NREQ, default 3, SHALL set the number of pattern requesters (2..8).
- REQ-003 Parameter DUR_W, default 8, SHALL set the width of each hold-duration field.
- REQ-004 Parameter PRESC_DIV, default 5000000, SHALL set the OSC_50m cycles per tick (100 ms at 50 MHz); legal range >=2.
- REQ-005 Parameter IDLE_PAT, default 0, SHALL set the LED_W-bit pattern driven while no request is held.
- REQ-006 OSC_50m  in  1  50 MHz clock; all state on its rising edge.
- REQ-007 FPGA_RSTn  in  1  reset, asynchronous, active-low.
- REQ-008 req_valid  in  NREQ  requester i offers a pattern.
- REQ-009 req_ready  out  NREQ  grant strobe to requester i.
- REQ-010 req_pattern  in  NREQ*LED_W  pattern of requester i at bits [i*LED_W +: LED_W].
- REQ-011 req_dur  in  NREQ*DUR_W  hold time in ticks of requester i at bits [i*DUR_W +: DUR_W].
- REQ-012 USER_LED  out  LED_W  LED array drive.
- REQ-013 busy  out  1  high in LOAD and HOLD.
- REQ-014 grant_id  out  clog2(NREQ)  index of the requester last transferred.

Function
- REQ-015 Prescaler SHALL count 0..PRESC_DIV-1, wrap to 0, and pulse tick for one cycle when the count equals PRESC_DIV-1; it SHALL run free in every FSM state.
- REQ-016 FSM states SHALL be IDLE, LOAD, HOLD.
- REQ-017 IDLE: when any req_valid is high, the block SHALL select the winner round-robin, searching from (rr_ptr+1) mod NREQ upward, and go to LOAD on the next edge.
- REQ-018 LOAD: req_ready SHALL be high for exactly one cycle, only for the winner; all other req_ready bits SHALL be 0 in every state.
- REQ-019 Transfer SHALL occur when req_valid[w] and req_ready[w] are both high; on that edge USER_LED <= req_pattern[w], hold counter <= req_dur[w], grant_id <= w, rr_ptr <= w, state <= HOLD.
- REQ-020 req_dur of 0 SHALL be loaded as 1.
- REQ-021 If req_valid[w] is low in LOAD, the block SHALL return to IDLE with no transfer and no change to USER_LED, rr_ptr, or grant_id.
- REQ-022 HOLD: the hold counter SHALL decrement on each tick; on the tick where it is 1, the block SHALL go to IDLE and USER_LED <= IDLE_PAT on the same edge.
- REQ-023 A tick coincident with the transfer edge SHALL NOT decrement; counting starts on the first tick after the transfer.
- REQ-024 A back-to-back request SHALL be granted with a minimum of 1 IDLE cycle between HOLD exit and the next LOAD.
- REQ-025 req_valid changes during HOLD SHALL have no effect, except as stated in REQ-030.

Reset
- REQ-026 FPGA_RSTn SHALL be synchronized by a 2-flop chain: async assert, deassert after 2 OSC_50m edges.
- REQ-027 On reset: state=IDLE, USER_LED=IDLE_PAT, req_ready=0, busy=0, grant_id=0, rr_ptr=NREQ-1 so requester 0 has first priority, prescaler=0, hold counter=0.
- REQ-028 Reset asserted mid-HOLD or mid-LOAD SHALL abort at once with no transfer; after release, operation SHALL resume from IDLE.

Configuration
- REQ-029 Macro LED_ARB_PREEMPT_EN SHALL compile preemption in or out.
- REQ-030 With LED_ARB_PREEMPT_EN defined: in HOLD with grant_id!=0 and req_valid[0] high, the block SHALL go to LOAD with w=0 on the next edge, discarding the remaining hold. Requester 0 is never preempted.
- REQ-031 Without LED_ARB_PREEMPT_EN: HOLD SHALL always run to completion.

Structure
- REQ-032 Package led_pkg SHALL hold the FSM state enum (IDLE/LOAD/HOLD) and the default constants LED_W=8 and IDLE_PAT=0.
- REQ-033 Round-robin winner selection SHALL be the sub-module led_rr_pick: a purely combinational function of the valid vector and rr_ptr, producing the winner index and a found flag.

Verification
Bench settings: PRESC_DIV=4, NREQ=3.
- REQ-034 Single request: valid0=1, pattern 8'hA5, dur 3 -> ready0 pulses 1 cycle; USER_LED=A5 for 3 ticks (12 cycles ±3); then USER_LED=00, busy=0.
- REQ-035 Fairness: valid0, valid1 and valid2 held high, dur 1 each -> grant order 0,1,2,0; grant_id follows that order.
- REQ-036 Valid dropped in LOAD: valid1 pulses 1 cycle -> no transfer, USER_LED stays 00, FSM returns to IDLE, rr_ptr unchanged.
- REQ-037 dur=0 with pattern 8'hFF -> USER_LED=FF for exactly 1 tick.
- REQ-038 Reset mid-HOLD: assert FPGA_RSTn low -> USER_LED=00 and busy=0 immediately; after release the next grant goes to requester 0.
- REQ-039 With LED_ARB_PREEMPT_EN: requester 2 holding dur 10, then valid0 with 8'h81 -> USER_LED=81 within 3 cycles. Without the macro: 8'h81 is shown only after requester 2's 10 ticks expire.
